multicycle_control: RTL

Multicycle control unit for the MIPS datapath. It is the producer side of the 3-bit ALU operation code and of every datapath enable. A state register sequences each instruction through IF/ID/EXE/MEM/WB. Per-state decode of the registered opcode drives ALU operation, write enables, mux selects and PC update. It sits between the instruction register (opcode field) plus the ALU zero flag and the datapath.

---
 rtl/multicycle_control_pkg.sv | 70 +++++++
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control_alu_op_decode.sv | 32 +++
 rtl/multicycle_control.sv | 112 +++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALU
// operation codes (also used by the ALU), FSM state codes and PC source codes.
package mips_ctrl_pkg;

  // Opcode field [31:26] of the instruction register
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLT = 3'b010,
    ALU_SRL = 3'b011,
    ALU_SLL = 3'b100,
    ALU_OR  = 3'b101,
    ALU_AND = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EXE_AL  = 4'd2,
    S_WB_AL   = 4'd3,
    S_EXE_BR  = 4'd4,
    S_EXE_MEM = 4'd5,
    S_MEM     = 4'd6,
    S_WB_LD   = 4'd7,
    S_HALT    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  // Coarse grouping of states, enough to pick the ALU operation
  typedef enum logic [1:0] {
    CLS_FETCH  = 2'd0,
    CLS_ALU    = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_MEM    = 2'd3
  } state_class_e;

  // Instructions that run through EXE_AL / WB_AL
  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
           (op == OP_OR)  || (op == OP_AND) || (op == OP_ORI)  ||
           (op == OP_SLL) || (op == OP_SLT);
  endfunction

  // Register-register forms write rd instead of rt
  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
           (op == OP_AND) || (op == OP_SLL) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control unit and the MIPS datapath.
// No handshake: every signal is a level valid for the current clock cycle;
// the datapath drives opcode/zero, the control unit drives all enables.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       RegWre;
  logic       RegDst;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ExtSel;
  logic [2:0] ALUOp;
  logic       mRD;
  logic       mWR;
  logic       DBDataSrc;
  logic [1:0] PCSrc;

  modport master (
    input  opcode, zero,
    output PCWre, IRWre, InsMemRW, RegWre, RegDst, ALUSrcA, ALUSrcB,
           ExtSel, ALUOp, mRD, mWR, DBDataSrc, PCSrc
  );

  modport slave (
    output opcode, zero,
    input  PCWre, IRWre, InsMemRW, RegWre, RegDst, ALUSrcA, ALUSrcB,
           ExtSel, ALUOp, mRD, mWR, DBDataSrc, PCSrc
  );
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational ALU operation select from opcode and the class of the
// current state. Address arithmetic for memory ops is an add, branch
// compare is a subtract, and ALU instructions decode their own operation.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  state_class_e st_class,
  output alu_op_e      alu_op
);

  // Select operation by state class, then by opcode for ALU instructions
  always_comb begin
    alu_op = ALU_ADD;
    case (st_class)
      CLS_ALU: begin
        case (opcode)
          OP_ADD, OP_ADDI: alu_op = ALU_ADD;
          OP_SUB:          alu_op = ALU_SUB;
          OP_SLT:          alu_op = ALU_SLT;
          OP_SLL:          alu_op = ALU_SLL;
          OP_OR, OP_ORI:   alu_op = ALU_OR;
          OP_AND:          alu_op = ALU_AND;
          default:         alu_op = ALU_ADD;
        endcase
      end
      CLS_BRANCH: alu_op = ALU_SUB;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: sequences each instruction through
// IF/ID/EXE/MEM/WB and decodes the datapath enables per state.
// Outputs are combinational from state, opcode and zero, and are
// forced low while rst_n is asserted.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_if.master       bus,
  output logic [3:0]                 state
);

  state_e       state_q, state_d;
  state_class_e st_class;
  alu_op_e      alu_op;

  logic op_j, op_halt, op_beq, op_lw, op_sw, op_alu;

  assign op_j    = (bus.opcode == OP_J);
  assign op_halt = (bus.opcode == OP_HALT);
  assign op_beq  = (bus.opcode == OP_BEQ);
  assign op_lw   = (bus.opcode == OP_LW);
  assign op_sw   = (bus.opcode == OP_SW);
  assign op_alu  = is_alu_op(bus.opcode);

  // Next-state selection; undefined opcodes fall back to IF after ID
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (op_j)                state_d = S_IF;
        else if (op_halt)        state_d = S_HALT;
        else if (op_beq)         state_d = S_EXE_BR;
        else if (op_lw || op_sw) state_d = S_EXE_MEM;
        else if (op_alu)         state_d = S_EXE_AL;
        else                     state_d = S_IF;
      end
      S_EXE_AL:  state_d = S_WB_AL;
      S_WB_AL:   state_d = S_IF;
      S_EXE_BR:  state_d = S_IF;
      S_EXE_MEM: state_d = S_MEM;
      S_MEM:     state_d = op_lw ? S_WB_LD : S_IF;
      S_WB_LD:   state_d = S_IF;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IF;
    endcase
  end

  // State register; reset aborts any instruction and returns to IF
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Group states so the ALU decoder only sees what it needs
  always_comb begin
    st_class = CLS_FETCH;
    case (state_q)
      S_EXE_AL, S_WB_AL:         st_class = CLS_ALU;
      S_EXE_BR:                  st_class = CLS_BRANCH;
      S_EXE_MEM, S_MEM, S_WB_LD: st_class = CLS_MEM;
      default:                   st_class = CLS_FETCH;
    endcase
  end

  alu_op_decode u_alu_op_decode (
    .opcode   (bus.opcode),
    .st_class (st_class),
    .alu_op   (alu_op)
  );

  // Datapath enables; all held low during reset
  always_comb begin
    bus.PCWre     = 1'b0;
    bus.IRWre     = 1'b0;
    bus.InsMemRW  = 1'b0;
    bus.RegWre    = 1'b0;
    bus.RegDst    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.ExtSel    = 1'b0;
    bus.ALUOp     = ALU_ADD;
    bus.mRD       = 1'b0;
    bus.mWR       = 1'b0;
    bus.DBDataSrc = 1'b0;
    bus.PCSrc     = PC_NEXT;
    if (rst_n) begin
      bus.InsMemRW  = (state_q == S_IF);
      bus.IRWre     = (state_q == S_IF);
      // PC advances in whichever state closes the instruction
      bus.PCWre     = (state_q != S_IF) && (state_q != S_HALT) && (state_d == S_IF);
      bus.RegWre    = (state_q == S_WB_AL) || (state_q == S_WB_LD);
      bus.DBDataSrc = (state_q == S_WB_LD);
      bus.mWR       = (state_q == S_MEM) && op_sw;
      bus.mRD       = ((state_q == S_MEM) || (state_q == S_WB_LD)) && op_lw;
      bus.RegDst    = is_rtype(bus.opcode);
      bus.ALUSrcA   = (bus.opcode == OP_SLL);
      bus.ALUSrcB   = (bus.opcode == OP_ADDI) || (bus.opcode == OP_ORI) || op_lw || op_sw;
      bus.ExtSel    = (bus.opcode != OP_ORI);
      bus.ALUOp     = alu_op;
      if ((state_q == S_ID) && op_j)
        bus.PCSrc = PC_JUMP;
      else if ((state_q == S_EXE_BR) && bus.zero)
        bus.PCSrc = PC_BRANCH;
    end
  end

endmodule
